// File: rtl/moving_average_pkg.sv
// rtl/moving_average_pkg.sv - shared types and constants for the boxcar averager
package moving_average_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_READ   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam int DEF_N_LOG2    = 8;
    localparam int DEF_X_WIDTH   = 12;
    localparam int DEF_SUM_WIDTH = DEF_X_WIDTH + DEF_N_LOG2;

    // Running-sum width: one full sample scaled by the window length
    function automatic int sum_width(input int x_width, input int n_log2);
        return x_width + n_log2;
    endfunction

endpackage

// File: rtl/moving_average_sample_ram.sv
// rtl/moving_average_sample_ram.sv - circular sample buffer, one sync read port and one write port
module moving_average_sample_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Read data register holds its value until the next read is issued
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Contents are not reset; the averager clears them itself after reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/moving_average.sv
// rtl/moving_average.sv - boxcar averager over the last 2**N_LOG2 ADC samples
module moving_average
    import moving_average_pkg::*;
#(
    parameter int N_LOG2  = DEF_N_LOG2,
    parameter int X_WIDTH = DEF_X_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [X_WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [X_WIDTH-1:0] out_data,
    output logic               primed
);

    localparam int SUM_WIDTH  = sum_width(X_WIDTH, N_LOG2);
    localparam int FILL_WIDTH = N_LOG2 + 1;

    localparam logic [N_LOG2-1:0]     PTR_LAST = {N_LOG2{1'b1}};
    localparam logic [FILL_WIDTH-1:0] WINDOW   = {1'b1, {N_LOG2{1'b0}}};

    state_t                state_q, state_d;
    logic [N_LOG2-1:0]     ptr_q, ptr_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic [X_WIDTH-1:0]    sample_q, sample_d;
    logic [FILL_WIDTH-1:0] fill_q, fill_d;
    logic [X_WIDTH-1:0]    out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  primed_q, primed_d;
    logic                  in_ready_q, in_ready_d;

    logic                  ram_we;
    logic [X_WIDTH-1:0]    ram_wdata;
    logic                  ram_re;
    logic [X_WIDTH-1:0]    ram_rdata;
    logic [SUM_WIDTH:0]    sum_ext;

    moving_average_sample_ram #(
        .ADDR_WIDTH (N_LOG2),
        .DATA_WIDTH (X_WIDTH)
    ) u_sample_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (ptr_q),
        .wr_data (ram_wdata),
        .rd_en   (ram_re),
        .rd_addr (ptr_q),
        .rd_data (ram_rdata)
    );

    // Next-state logic: clear sweep, accept, fetch oldest sample, then retire it from the sum
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sum_d       = sum_q;
        sample_d    = sample_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        primed_d    = primed_q;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        ram_re      = 1'b0;
        sum_ext     = '0;

        case (state_q)
            ST_CLEAR: begin
                // Zero one slot per cycle so warm-up averages ramp from zero
                ram_we = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    sample_d = in_data;
                    ram_re   = 1'b1;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                // ram_rdata is the sample leaving the window; one extra bit holds the
                // transient difference, and a negative result would mean a corrupt sum
                sum_ext = {1'b0, sum_q}
                        + {{(N_LOG2 + 1){1'b0}}, sample_q}
                        - {{(N_LOG2 + 1){1'b0}}, ram_rdata};
                sum_d = sum_ext[SUM_WIDTH] ? '0 : sum_ext[SUM_WIDTH-1:0];

                ram_we      = 1'b1;
                ram_wdata   = sample_q;
                ptr_d       = ptr_q + 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = sum_d[SUM_WIDTH-1:N_LOG2];

                if (fill_q != WINDOW) begin
                    fill_d = fill_q + 1'b1;
                end
                if (fill_d == WINDOW) begin
                    primed_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign in_ready_d = (state_d == ST_IDLE);

    // State and output registers; reset restarts the clear sweep from slot 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            sum_q       <= '0;
            sample_q    <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sum_q       <= sum_d;
            sample_q    <= sample_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            primed_q    <= primed_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign primed    = primed_q;

endmodule

// File: tb/tb_moving_average.sv
// tb/tb_moving_average.sv - scoreboard bench for moving_average against a window-sum model
module tb_moving_average;

    localparam int WIN = 256;

    typedef struct {
        int   data;
        logic primed;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] out_data;
    logic        primed;

    int   tests;
    int   failed;
    int   total_accepted;
    int   accepted_cnt;
    int   hist[$];
    exp_t exp_q[$];

    moving_average dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Reference: average of the last WIN accepted samples, zeros before that
    always @(negedge clk) begin
        if (reset_n && in_valid && in_ready) begin
            exp_t e;
            longint s;
            hist.push_back(int'(in_data));
            if (hist.size() > WIN) void'(hist.pop_front());
            total_accepted++;
            accepted_cnt++;
            s = 0;
            foreach (hist[i]) s += hist[i];
            e.data   = int'(s / WIN);
            e.primed = (total_accepted >= WIN);
            exp_q.push_back(e);
        end
    end

    // Output monitor
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            exp_t e;
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_out_valid out_data=%0d primed=%0b", out_data, primed);
            end else begin
                e = exp_q.pop_front();
                if (int'(out_data) != e.data || primed !== e.primed) begin
                    failed++;
                    $display("FAIL sample actual out_data=%0d primed=%0b expected out_data=%0d primed=%0b",
                             out_data, primed, e.data, e.primed);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic release_and_count();
        int n;
        reset_n = 1'b1;
        n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("clear_cycles", n, WIN);
        check("idle_out_data", int'(out_data), 0);
        check("idle_primed", int'(primed), 0);
    endtask

    task automatic send(input int d);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d[11:0];
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("send_timeout", n, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0; failed = 0; total_accepted = 0; accepted_cnt = 0;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_primed", int'(primed), 0);
        check("rst_in_ready", int'(in_ready), 0);
        release_and_count();

        for (int i = 0; i < WIN; i++) send(4095);
        drain();
        check("full_out_data", int'(out_data), 4095);
        check("full_primed", int'(primed), 1);

        for (int i = 0; i < WIN; i++) send(0);
        drain();
        check("empty_out_data", int'(out_data), 0);
        check("empty_primed", int'(primed), 1);

        for (int i = 0; i < WIN; i++) send(100);
        for (int i = 0; i < 300; i++) send((i % 2) ? 200 : 0);
        drain();
        check("wrap_out_data", int'(out_data), 100);

        for (int i = 0; i < 50; i++) send(int'($urandom_range(0, 4095)));
        drain();

        begin
            int a0;
            a0 = accepted_cnt;
            in_valid = 1'b1;
            for (int cyc = 0; cyc < 30; cyc++) begin
                in_data = cyc[11:0];
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            drain();
            check("busy_accepts", accepted_cnt - a0, 10);
        end

        in_valid = 1'b1;
        in_data  = 12'd777;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_primed", int'(primed), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        hist.delete();
        total_accepted = 0;
        @(posedge clk); #1;
        release_and_count();
        send(256);
        drain();
        check("post_rst_out_data", int'(out_data), 1);
        check("post_rst_primed", int'(primed), 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/moving_average.md
# moving_average

Boxcar averager for the ADC sample stream: it averages the most recent 2**N_LOG2 raw 12-bit ADC conversions. It sits directly upstream of the ADC-to-voltage scaling stage and drives the averaged-sample signal that stage converts to millivolts. Samples live in a circular buffer backed by a small synchronous RAM, and a running sum is updated incrementally, so each new sample costs one add and one subtract.

## Interface
Parameters:
- N_LOG2, default 8: log2 of the window length (256 samples).
- X_WIDTH, default 12: width of one ADC sample.

Ports:
- clk, input, 1: system clock. One clock domain.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_data holds a new ADC conversion this cycle.
- in_data, input, X_WIDTH: raw ADC sample (unsigned).
- in_ready, output, 1: block accepts a sample this cycle.
- out_valid, output, 1: one-cycle pulse; out_data has just been updated.
- out_data, output, X_WIDTH: window average = sum >> N_LOG2, truncated (no rounding). Holds between updates.
- primed, output, 1: high once 2**N_LOG2 samples have been accepted since reset. Sticky until reset.

## Operation
- State machine: CLEAR → IDLE → READ → UPDATE → IDLE.
- CLEAR
  - Entered on reset.
  - Writes zero to RAM address ptr each cycle and increments ptr.
  - When ptr wraps back to 0 (after 2**N_LOG2 cycles), goes to IDLE.
  - in_ready=0; in_valid is ignored, not queued.
- IDLE
  - in_ready=1.
  - On in_valid: latch in_data into sample_q, issue a RAM read at ptr, go to READ.
- READ
  - RAM output (oldest sample, old) becomes valid. Go to UPDATE.
- UPDATE
  - sum <= sum + sample_q − old. Intermediate is X_WIDTH+N_LOG2+1 bits; the result always fits X_WIDTH+N_LOG2 bits and is never negative.
  - Write sample_q to RAM at ptr, then ptr <= ptr+1. ptr wraps modulo 2**N_LOG2.
  - out_valid <= 1.
  - out_data <= (new sum)[X_WIDTH+N_LOG2−1 : N_LOG2].
  - Increment the fill counter, which saturates at 2**N_LOG2; primed <= 1 when the count reaches 2**N_LOG2.
  - Go to IDLE.
- Warm-up: the buffer starts all-zero, so the average ramps up. After k accepted samples (k < window), out_data = floor(sum of samples / 2**N_LOG2).
- in_valid while in_ready=0 (READ, UPDATE or CLEAR): the sample is dropped; no side effects.

## Timing
- Reset values (asynchronous, all outputs): state=CLEAR, ptr=0, sum=0, sample_q=0, fill=0, out_data=0, out_valid=0, primed=0, in_ready=0.
- After reset deasserts: CLEAR lasts exactly 2**N_LOG2 cycles (256 by default); in_ready rises on the following cycle.
- Handshake:
  - Accept at clock edge E (in_valid & in_ready).
  - in_ready is low for the cycles after E and E+1, then high again after E+2.
  - out_valid is high for exactly the one cycle after edge E+2.
  - out_data changes at edge E+2.
  - Throughput: one sample per 3 cycles. The ADC rate is orders of magnitude slower.
- RAM is read-first at a single address per transaction; read and write to the same address never occur in the same cycle.
- Reset asserted mid-operation (READ or UPDATE): the in-flight sample is discarded and CLEAR restarts from ptr=0.
- primed rises in the same cycle as the out_valid of the 2**N_LOG2-th sample.

## Structure
- Package moving_average_pkg holds:
  - state_t enum (CLEAR, IDLE, READ, UPDATE);
  - default N_LOG2 and X_WIDTH constants;
  - derived SUM_WIDTH = X_WIDTH+N_LOG2.
- Sub-module sample_ram holds the buffer:
  - depth 2**N_LOG2, width X_WIDTH;
  - one synchronous read port (registered output) and one write port;
  - no reset on contents.
- The top holds the FSM, ptr, fill counter, sum and output registers.

## Test plan
- Reset, then idle:
  - in_ready=0 for exactly 256 cycles after reset_n rises, then in_ready=1.
  - out_data=0, primed=0, out_valid never pulses.
- Feed 256 samples of 4095 through the handshake:
  - the k-th out_valid shows out_data = floor(4095*k/256);
  - the 256th shows 4095 with primed=1.
- Continue with 256 samples of 0:
  - the k-th shows floor(4095*(256−k)/256);
  - the final value is 0 and primed stays 1.
- Wrap-around: after priming with 100, feed 300 samples alternating 0 and 200 → out_data settles to 100 (window holds 128 of each), with no glitch at the ptr wrap.
- Busy drop: hold in_valid=1 continuously with in_data = the cycle count → exactly one sample accepted per 3 cycles; the sum matches a software model of only the accepted samples.
- Reset mid-UPDATE (reset_n low for 1 cycle) → all outputs return to reset values immediately; a 256-cycle CLEAR follows; the next sample of 256 gives out_data=1.
